// File: rtl/haz_pkg.sv
// Shared constants for the pipeline hazard controller and the multiply/divide unit.
package haz_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } haz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default occupancy, also used by the multiply/divide unit itself.
    localparam int MDU_CYCLES_DEF = 32;
    localparam int MDU_CNT_W      = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle between the pipeline (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_mdu_use;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic             mdu_start;
    logic             pc_we;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_mdu_use,
        output ex_mem_read, ex_rd, br_taken, mdu_start,
        input  pc_we, if_id_stall, if_id_flush, id_ex_bubble,
        input  mdu_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_mdu_use,
        input  ex_mem_read, ex_rd, br_taken, mdu_start,
        output pc_we, if_id_stall, if_id_flush, id_ex_bubble,
        output mdu_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Loadable down-counter tracking multiply/divide occupancy.
module mdu_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - 1'b1;
        end else if (load) begin
            busy_d = 1'b1;
            cnt_d  = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use, taken-branch flush and MDU interlock.
// MDU interlock is built only when HAZ_MDU_INTERLOCK_EN is defined.
module pipe_hazard_ctrl
    import haz_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.slave bus
);
    logic             load_use;
    logic             mdu_hz;
    logic             mdu_busy;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) &&
                      ((bus.ex_rd == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

`ifdef HAZ_MDU_INTERLOCK_EN
    haz_state_e state_q, state_d;
    logic       tmr_load;
    logic       tmr_busy;
    logic       tmr_done;

    assign tmr_load = (state_q == RUN) && bus.mdu_start;

    mdu_timer #(
        .W (MDU_CNT_W)
    ) u_mdu_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (tmr_load),
        .load_val (MDU_CNT_W'(MDU_CYCLES - 1)),
        .busy     (tmr_busy),
        .done     (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (bus.mdu_start) state_d = MDU_BUSY;
            MDU_BUSY: if (tmr_done || !tmr_busy) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    assign mdu_busy = (state_q == MDU_BUSY);
    assign mdu_hz   = mdu_busy && bus.id_mdu_use;
`else
    logic unused_mdu;
    assign unused_mdu = ^{bus.mdu_start, bus.id_mdu_use, 32'(MDU_CYCLES)};
    assign mdu_busy   = 1'b0;
    assign mdu_hz     = 1'b0;
`endif

    // Reset forces a full hold so nothing enters the pipe until release.
    always_comb begin
        bus.pc_we        = 1'b1;
        bus.if_id_stall  = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        if (!rst) begin
            bus.pc_we        = 1'b0;
            bus.if_id_stall  = 1'b1;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (bus.br_taken) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end else if (load_use || mdu_hz) begin
            bus.pc_we        = 1'b0;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_bubble = 1'b1;
        end
    end

    assign stall = bus.if_id_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign bus.mdu_busy  = mdu_busy;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
